// File: rtl/reg_write_stage.sv
// Dual-port register-file write stage: registers two write requests, drives
// one-hot wordlines, resolves same-id conflicts and offers a read bypass.
module reg_write_stage #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 16,
    parameter int ZERO_RO = 0,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       wr_en0,
    input  logic [ADDR_W-1:0]          wr_id0,
    input  logic [DATA_W-1:0]          wr_data0,
    input  logic                       wr_en1,
    input  logic [ADDR_W-1:0]          wr_id1,
    input  logic [DATA_W-1:0]          wr_data1,
    output logic [(1 << ADDR_W)-1:0]   wordline0,
    output logic [(1 << ADDR_W)-1:0]   wordline1,
    output logic [DATA_W-1:0]          wdata0,
    output logic [DATA_W-1:0]          wdata1,
    output logic                       conflict,
    input  logic [ADDR_W-1:0]          rd_id,
    output logic                       byp_hit,
    output logic [DATA_W-1:0]          byp_data,
    output logic [CNT_W-1:0]           wr_count
);

    localparam int NUM_REGS = 1 << ADDR_W;
    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};
    localparam logic ZERO_PROT = (ZERO_RO != 0);

    // Stage registers
    logic              v0, v1, conf;
    logic [ADDR_W-1:0] id0, id1;
    logic [DATA_W-1:0] d0, d1;
    logic [CNT_W-1:0]  cnt;

    // Next-capture values derived from the incoming requests
    logic       e0, e1, same_id;
    logic       nxt_v0, nxt_v1, nxt_conf;
    logic [CNT_W:0] cnt_sum;
    logic [CNT_W-1:0] cnt_next;

    function automatic logic [NUM_REGS-1:0] decode(input logic valid,
                                                   input logic [ADDR_W-1:0] id);
        decode = '0;
        if (valid) decode[id] = 1'b1;
    endfunction

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        e0       = wr_en0 & ~(ZERO_PROT & (wr_id0 == '0));
        e1       = wr_en1 & ~(ZERO_PROT & (wr_id1 == '0));
        same_id  = e0 & e1 & (wr_id0 == wr_id1);
        // Younger instruction (port 1) wins a same-register collision.
        nxt_v0   = e0 & ~same_id;
        nxt_v1   = e1;
        nxt_conf = same_id;
    end

    // Retire whatever currently sits in the stage; saturate instead of wrapping.
    always_comb begin
        cnt_sum  = {1'b0, cnt} + {{CNT_W{1'b0}}, v0} + {{CNT_W{1'b0}}, v1};
        cnt_next = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0   <= 1'b0;
            v1   <= 1'b0;
            conf <= 1'b0;
            id0  <= '0;
            id1  <= '0;
            d0   <= '0;
            d1   <= '0;
            cnt  <= '0;
        end else if (flush) begin
            // Flush beats stall; ids, data and the counter are left alone.
            v0   <= 1'b0;
            v1   <= 1'b0;
            conf <= 1'b0;
        end else if (!stall) begin
            v0   <= nxt_v0;
            v1   <= nxt_v1;
            conf <= nxt_conf;
            id0  <= wr_id0;
            id1  <= wr_id1;
            d0   <= wr_data0;
            d1   <= wr_data1;
            cnt  <= cnt_next;
        end
    end

    assign wordline0 = decode(v0, id0);
    assign wordline1 = decode(v1, id1);
    assign wdata0    = d0;
    assign wdata1    = d1;
    assign conflict  = conf;
    assign wr_count  = cnt;

    // Port 1 holds the younger value, so it is checked first.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        if (v1 && (id1 == rd_id)) begin
            byp_hit  = 1'b1;
            byp_data = d1;
        end else if (v0 && (id0 == rd_id)) begin
            byp_hit  = 1'b1;
            byp_data = d0;
        end
    end

    wordlines_exclusive: assert property (
        @(posedge clk) disable iff (!rst_n) (wordline0 & wordline1) == '0
    );

endmodule

// File: tb/tb_reg_write_stage.sv
// Directed bench for reg_write_stage: default build plus ZERO_RO=1 and CNT_W=2 builds.
module tb_reg_write_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush;
    logic        wr_en0, wr_en1;
    logic [3:0]  wr_id0, wr_id1, rd_id;
    logic [15:0] wr_data0, wr_data1;

    logic [15:0] wl0, wl1, wd0, wd1, bdata;
    logic        conf, hit;
    logic [7:0]  cnt;

    logic [15:0] z_wl0, z_wl1, z_wd0, z_wd1, z_bdata;
    logic        z_conf, z_hit;
    logic [7:0]  z_cnt;

    logic [15:0] c_wl0, c_wl1, c_wd0, c_wd1, c_bdata;
    logic        c_conf, c_hit;
    logic [1:0]  c_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_write_stage u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .wr_en0(wr_en0), .wr_id0(wr_id0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_id1(wr_id1), .wr_data1(wr_data1),
        .wordline0(wl0), .wordline1(wl1), .wdata0(wd0), .wdata1(wd1),
        .conflict(conf), .rd_id(rd_id), .byp_hit(hit), .byp_data(bdata),
        .wr_count(cnt)
    );

    reg_write_stage #(.ZERO_RO(1)) u_zro (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .wr_en0(wr_en0), .wr_id0(wr_id0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_id1(wr_id1), .wr_data1(wr_data1),
        .wordline0(z_wl0), .wordline1(z_wl1), .wdata0(z_wd0), .wdata1(z_wd1),
        .conflict(z_conf), .rd_id(rd_id), .byp_hit(z_hit), .byp_data(z_bdata),
        .wr_count(z_cnt)
    );

    reg_write_stage #(.CNT_W(2)) u_c2 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .wr_en0(wr_en0), .wr_id0(wr_id0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_id1(wr_id1), .wr_data1(wr_data1),
        .wordline0(c_wl0), .wordline1(c_wl1), .wdata0(c_wd0), .wdata1(c_wd1),
        .conflict(c_conf), .rd_id(rd_id), .byp_hit(c_hit), .byp_data(c_bdata),
        .wr_count(c_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0;
        wr_en0 = 0; wr_id0 = 0; wr_data0 = 0;
        wr_en1 = 0; wr_id1 = 0; wr_data1 = 0;
    endtask

    task automatic set_writes(input logic e0, input logic [3:0] i0, input logic [15:0] dd0,
                              input logic e1, input logic [3:0] i1, input logic [15:0] dd1);
        wr_en0 = e0; wr_id0 = i0; wr_data0 = dd0;
        wr_en1 = e1; wr_id1 = i1; wr_data1 = dd1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        rd_id = 0;
        rst_n = 0;
        #12;
        check("rst_wl0", wl0, 0);
        check("rst_wl1", wl1, 0);
        check("rst_wdata0", wd0, 0);
        check("rst_conflict", conf, 0);
        check("rst_count", cnt, 0);
        check("rst_byp_hit", hit, 0);
        check("rst_byp_data", bdata, 0);
        rst_n = 1;

        // Single port-0 write, one-cycle latency then gone
        @(posedge clk); #1;
        set_writes(1, 5, 16'hBEEF, 0, 0, 0);
        tick();
        check("p0_wl0", wl0, 16'h0020);
        check("p0_wdata0", wd0, 16'hBEEF);
        check("p0_wl1", wl1, 0);
        check("p0_conflict", conf, 0);
        set_writes(0, 0, 0, 0, 0, 0);
        tick();
        check("p0_wl0_clear", wl0, 0);
        check("p0_count", cnt, 1);

        // Same-id conflict: port 1 wins
        set_writes(1, 9, 16'h1111, 1, 9, 16'h2222);
        tick();
        check("cf_wl1", wl1, 16'h0200);
        check("cf_wdata1", wd1, 16'h2222);
        check("cf_wl0", wl0, 0);
        check("cf_conflict", conf, 1);
        rd_id = 9; #1;
        check("cf_byp_hit", hit, 1);
        check("cf_byp_data", bdata, 16'h2222);
        check("cf_count", cnt, 1);

        // Distinct ids: both wordlines, bypass from each port
        set_writes(1, 4, 16'hAAAA, 1, 7, 16'h5555);
        tick();
        check("dual_wl0", wl0, 16'h0010);
        check("dual_wl1", wl1, 16'h0080);
        check("dual_conflict", conf, 0);
        check("dual_count", cnt, 2);
        rd_id = 4; #1;
        check("byp_p0_data", bdata, 16'hAAAA);
        rd_id = 7; #1;
        check("byp_p1_data", bdata, 16'h5555);
        rd_id = 2; #1;
        check("byp_miss_hit", hit, 0);
        check("byp_miss_data", bdata, 0);

        // Stall holds stage and counter; flush overrides stall
        set_writes(0, 0, 0, 1, 3, 16'h3333);
        tick();
        check("st_wl1", wl1, 16'h0008);
        check("st_count0", cnt, 4);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_writes(1, 4'(i + 10), 16'(i), 1, 4'(i + 12), 16'(i + 7));
            tick();
            check("st_wl1_hold", wl1, 16'h0008);
            check("st_wl0_hold", wl0, 0);
            check("st_count_hold", cnt, 4);
        end
        flush = 1;
        tick();
        check("fl_wl0", wl0, 0);
        check("fl_wl1", wl1, 0);
        check("fl_count", cnt, 4);
        idle_inputs();
        tick();
        check("fl_count_kept", cnt, 4);

        // Register 0 write protection
        set_writes(1, 0, 16'h0BAD, 0, 0, 0);
        tick();
        check("z0_wl0_default", wl0, 16'h0001);
        check("z0_wl0_prot", z_wl0, 0);
        rd_id = 0; #1;
        check("z0_byp_prot", z_hit, 0);
        check("z0_byp_default", hit, 1);
        set_writes(0, 0, 0, 0, 0, 0);
        tick();
        check("z0_count_default", cnt, 5);
        check("z0_count_prot", z_cnt, 4);

        // Asynchronous reset mid-cycle, with stall and flush held during reset
        set_writes(1, 2, 16'h00C2, 0, 0, 0);
        tick();
        check("ar_wl0_before", wl0, 16'h0004);
        #2;
        rst_n = 0;
        #1;
        check("ar_wl0", wl0, 0);
        check("ar_wdata0", wd0, 0);
        check("ar_count", cnt, 0);
        check("ar_byp_hit", hit, 0);
        stall = 1; flush = 1;
        tick();
        stall = 0; flush = 0;
        rst_n = 1;
        tick();
        check("ar_first_capture", wl0, 16'h0004);

        // Saturating counter with CNT_W=2
        rst_n = 0;
        idle_inputs();
        #2;
        rst_n = 1;
        set_writes(1, 1, 16'h0001, 1, 2, 16'h0002);
        tick();
        check("sat_count_a", c_cnt, 0);
        set_writes(1, 3, 16'h0003, 1, 4, 16'h0004);
        tick();
        check("sat_count_b", c_cnt, 2);
        set_writes(1, 5, 16'h0005, 1, 6, 16'h0006);
        tick();
        check("sat_count_c", c_cnt, 3);
        check("sat_excl", c_wl0 & c_wl1, 0);
        idle_inputs();
        tick();
        check("sat_count_d", c_cnt, 3);
        tick();
        check("sat_count_e", c_cnt, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_write_stage.md
Name: reg_write_stage

Overview:
- Parametrised, pipelined successor to the register-file write decoder.
- Accepts two write requests per cycle (port 0 = older instruction, port 1 = younger) and registers them in one write stage.
- Drives per-port one-hot wordlines from that stage.
- Resolves same-register conflicts, optionally write-protects register 0, and provides a read-bypass lookup into the pending writes.
- Sits between writeback and the register file array.

Parameters:
- ADDR_W, 4, register-id width; NUM_REGS = 2**ADDR_W (derived, not overridable).
- DATA_W, 16, write data width.
- ZERO_RO, 0, when 1, writes to register id 0 are discarded.
- CNT_W, 8, width of the committed-write counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  freeze write stage.
- flush  in  1  synchronously invalidate write stage.
- wr_en0  in  1  port 0 write request.
- wr_id0  in  ADDR_W  port 0 destination id.
- wr_data0  in  DATA_W  port 0 data.
- wr_en1  in  1  port 1 write request.
- wr_id1  in  ADDR_W  port 1 destination id.
- wr_data1  in  DATA_W  port 1 data.
- wordline0  out  NUM_REGS  one-hot port 0 write select.
- wordline1  out  NUM_REGS  one-hot port 1 write select.
- wdata0  out  DATA_W  registered port 0 data.
- wdata1  out  DATA_W  registered port 1 data.
- conflict  out  1  port 0 write was dropped this stage.
- rd_id  in  ADDR_W  bypass lookup id.
- byp_hit  out  1  rd_id matches a valid pending write.
- byp_data  out  DATA_W  forwarded data.
- wr_count  out  CNT_W  saturating count of committed writes.

Behaviour:
- Stage registers: v0, id0, d0, v1, id1, d1, conf, cnt.
- Reset (rst_n=0, asynchronous): all stage registers clear to 0 immediately.
  - wordline0, wordline1, wdata0, wdata1, conflict, wr_count are 0.
  - byp_hit is 0 and byp_data is 0.
- Effective enable: e_k = wr_en_k & ~(ZERO_RO & (wr_id_k == 0)).
- Conflict: when e0 & e1 & (wr_id0 == wr_id1):
  - port 1 wins (younger instruction);
  - captured v0 = 0 and conf = 1.
  - Otherwise conf = 0.
- Capture priority each rising edge:
  - flush=1: v0=v1=conf=0; ids and data don't-care but held. flush overrides stall.
  - else stall=1: all stage registers hold, cnt included. Wordlines stay asserted; the rewrite is idempotent.
  - else: load v0, v1, ids, data and conf from the current inputs.
- Outputs (decoded only from stage registers, so latency is exactly 1 cycle from request to wordline):
  - wordline_k = one-hot(id_k) when v_k, else all zeros.
  - wdata_k = d_k.
  - conflict = conf.
- By construction, wordline0 & wordline1 is never nonzero.
- Counter:
  - on each non-stalled, non-flushed edge, cnt += v0 + v1 (current stage contents being retired);
  - saturates at 2**CNT_W-1, never wraps;
  - flush does not clear cnt; only reset does.
- Bypass (combinational from stage registers and rd_id):
  - if v1 & id1 == rd_id: hit = 1, data = d1;
  - else if v0 & id0 == rd_id: hit = 1, data = d0;
  - else hit = 0, data = 0.
  - With ZERO_RO=1 and rd_id=0, hit is always 0.
- Reset asserted mid-stall or mid-flush: reset wins. The first edge after deassertion performs a normal capture.

Test Plan (defaults):
- Reset, then wr_en0=1, id0=5, data0=0xBEEF for one cycle -> next cycle wordline0=0x0020, wdata0=0xBEEF, wordline1=0, conflict=0; the following cycle wordline0=0.
- wr_en0=wr_en1=1, id0=id1=9, data0=0x1111, data1=0x2222 -> wordline1=0x0200, wdata1=0x2222, wordline0=0, conflict=1; rd_id=9 gives byp_hit=1, byp_data=0x2222.
- Capture id1=3; assert stall 3 cycles with changing inputs -> wordline1 stays 0x0008 and wr_count unchanged. Then flush=1 together with stall=1 -> wordlines 0 next cycle.
- ZERO_RO=1, wr_en0=1, id0=0 -> wordline0=0 and wr_count unchanged. ZERO_RO=0, same stimulus -> wordline0=0x0001.
- CNT_W=2, issue 3 consecutive dual writes to distinct ids -> wr_count reads 2, then 3 and stays 3.
- Assert rst_n=0 asynchronously while wordline0 is nonzero -> all outputs 0 before the next clock edge.
